// File: rtl/uart_tx_fifo.sv
// UART transmitter with a circular transmit FIFO and a valid/ready write port.
// Frames are start, DATA_BITS data bits LSB first, optional parity, then STOP_BITS stop bits.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]          count_reg;

  state_t               state_reg;
  logic [CW-1:0]        baud_reg;
  logic [BW-1:0]        bit_reg;
  logic                 stop_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_reg;
  logic                 tx_reg;

  logic                 do_write, do_pop, bit_end, fifo_empty, rd_parity;
  logic [DATA_BITS-1:0] rd_word;

  always_comb begin
    wr_ready   = (count_reg != FULL);
    do_write   = wr_valid & wr_ready;
    bit_end    = (baud_reg == DIV_LAST);
    fifo_empty = (count_reg == '0);
    // Pop from IDLE, or at the very end of the last stop bit for gapless frames.
    do_pop     = !fifo_empty &&
                 ((state_reg == IDLE) ||
                  (state_reg == STOP && bit_end && stop_reg == STOP_LAST));
    rd_word    = mem[rd_ptr_reg];
    rd_parity  = (PARITY == 1) ? ~^rd_word : ^rd_word;
    busy       = (state_reg != IDLE) || !fifo_empty;
    fifo_count = count_reg;
    tx         = tx_reg;
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + {{AW{1'b0}}, do_write} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      tx_reg    <= 1'b1;
      baud_reg  <= '0;
      bit_reg   <= '0;
      stop_reg  <= 1'b0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
    end else begin
      if (state_reg == IDLE || bit_end) baud_reg <= '0;
      else                              baud_reg <= baud_reg + 1'b1;

      case (state_reg)
        IDLE: begin
          if (do_pop) begin
            shift_reg <= rd_word;
            par_reg   <= rd_parity;
            tx_reg    <= 1'b0;
            state_reg <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx_reg    <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_reg   <= '0;
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_reg == BIT_LAST) begin
              if (PARITY != 0) begin
                tx_reg    <= par_reg;
                state_reg <= PARITY_BIT;
              end else begin
                tx_reg    <= 1'b1;
                stop_reg  <= 1'b0;
                state_reg <= STOP;
              end
            end else begin
              tx_reg    <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_reg   <= bit_reg + 1'b1;
            end
          end
        end
        PARITY_BIT: begin
          if (bit_end) begin
            tx_reg    <= 1'b1;
            stop_reg  <= 1'b0;
            state_reg <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_reg == STOP_LAST) begin
              if (do_pop) begin
                shift_reg <= rd_word;
                par_reg   <= rd_parity;
                tx_reg    <= 1'b0;
                state_reg <= START;
              end else begin
                state_reg <= IDLE;
              end
            end else begin
              stop_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover 8N1, even/odd parity and 7-bit/2-stop framing.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] wd0, wd1, wd2;
  logic [6:0] wd3;
  logic       wv0, wv1, wv2, wv3;
  logic       rdy0, rdy1, rdy2, rdy3;
  logic       tx0, tx1, tx2, tx3;
  logic       busy0, busy1, busy2, busy3;
  logic [3:0] cnt0, cnt1, cnt2, cnt3;

  uart_tx_fifo #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8)) u0 (
    .clk(clk), .reset(reset), .wr_data(wd0), .wr_valid(wv0), .wr_ready(rdy0),
    .tx(tx0), .busy(busy0), .fifo_count(cnt0));
  uart_tx_fifo #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8)) u1 (
    .clk(clk), .reset(reset), .wr_data(wd1), .wr_valid(wv1), .wr_ready(rdy1),
    .tx(tx1), .busy(busy1), .fifo_count(cnt1));
  uart_tx_fifo #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(8)) u2 (
    .clk(clk), .reset(reset), .wr_data(wd2), .wr_valid(wv2), .wr_ready(rdy2),
    .tx(tx2), .busy(busy2), .fifo_count(cnt2));
  uart_tx_fifo #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(8)) u3 (
    .clk(clk), .reset(reset), .wr_data(wd3), .wr_valid(wv3), .wr_ready(rdy3),
    .tx(tx3), .busy(busy3), .fifo_count(cnt3));

  int total = 0;
  int bad   = 0;

  // Per-cycle trace of the selected instance; index 0 is the edge after the first write.
  int         sel;
  logic       s_tx, s_busy, s_rdy;
  logic [3:0] s_cnt;
  logic       tx_log [2048];
  logic       busy_log [2048];
  logic       rdy_log [2048];
  logic       exp_log [2048];
  int         cnt_log [2048];
  int         li;
  int         peak;

  always_comb begin
    s_tx = tx0; s_busy = busy0; s_rdy = rdy0; s_cnt = cnt0;
    case (sel)
      1: begin s_tx = tx1; s_busy = busy1; s_rdy = rdy1; s_cnt = cnt1; end
      2: begin s_tx = tx2; s_busy = busy2; s_rdy = rdy2; s_cnt = cnt2; end
      3: begin s_tx = tx3; s_busy = busy3; s_rdy = rdy3; s_cnt = cnt3; end
      default: ;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
    li++;
    if (int'(s_cnt) > peak) peak = int'(s_cnt);
    if (li >= 0 && li < 2048) begin
      tx_log[li]   = s_tx;
      busy_log[li] = s_busy;
      rdy_log[li]  = s_rdy;
      cnt_log[li]  = int'(s_cnt);
    end
  endtask

  // Expected line waveform of one frame, 16 clocks per bit.
  task automatic add_frame(input int at, input logic [8:0] d, input int nbits,
                           input int par, input int stops);
    int k;
    int ones;
    logic pb;
    k = at;
    ones = 0;
    for (int c = 0; c < 16; c++) begin exp_log[k] = 1'b0; k++; end
    for (int b = 0; b < nbits; b++) begin
      if (d[b]) ones++;
      for (int c = 0; c < 16; c++) begin exp_log[k] = d[b]; k++; end
    end
    if (par != 0) begin
      pb = (par == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      for (int c = 0; c < 16; c++) begin exp_log[k] = pb; k++; end
    end
    for (int c = 0; c < 16 * stops; c++) begin exp_log[k] = 1'b1; k++; end
  endtask

  function automatic int first_diff(input int a, input int b);
    for (int i = a; i < b; i++)
      if (tx_log[i] !== exp_log[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    wd0 = '0; wd1 = '0; wd2 = '0; wd3 = '0;
    wv0 = 1'b0; wv1 = 1'b0; wv2 = 1'b0; wv3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (tx0 !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy0); end
    total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", cnt0); end
    total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", rdy0); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    $display("reset: checks done");
  endtask

  task automatic test_basic();
    int d;
    sel = 0; li = -2;
    wd0 = 8'h55; wv0 = 1'b1;
    step();
    wv0 = 1'b0;
    total++; if (cnt0 !== 4'd1) begin bad++; $display("FAIL basic_count_at_write: got %0d want 1", cnt0); end
    total++; if (tx0 !== 1'b1) begin bad++; $display("FAIL basic_tx_at_write: got %b want 1", tx0); end
    repeat (161) step();
    add_frame(0, 9'h55, 8, 0, 1);
    exp_log[160] = 1'b1;
    d = first_diff(0, 161);
    total++; if (d != -1) begin bad++; $display("FAIL basic_frame: cycle %0d got %b want %b", d, tx_log[d], exp_log[d]); end
    total++; if (cnt_log[0] != 0) begin bad++; $display("FAIL basic_count_popped: got %0d want 0", cnt_log[0]); end
    total++; if (busy_log[159] !== 1'b1) begin bad++; $display("FAIL basic_busy_last: got %b want 1", busy_log[159]); end
    total++; if (busy_log[160] !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy_log[160]); end
    $display("basic: frame 0x55 8N1 observed");
  endtask

  task automatic test_parity();
    int d;
    // even parity, 0x07 -> parity bit 1
    sel = 1; li = -2;
    wd1 = 8'h07; wv1 = 1'b1;
    step();
    wv1 = 1'b0;
    repeat (177) step();
    add_frame(0, 9'h07, 8, 2, 1);
    exp_log[176] = 1'b1;
    d = first_diff(0, 177);
    total++; if (d != -1) begin bad++; $display("FAIL even_frame: cycle %0d got %b want %b", d, tx_log[d], exp_log[d]); end
    total++; if (tx_log[152] !== 1'b1) begin bad++; $display("FAIL even_parity_bit: got %b want 1", tx_log[152]); end
    total++; if (busy_log[175] !== 1'b1 || busy_log[176] !== 1'b0)
      begin bad++; $display("FAIL even_length: busy %b%b want 10", busy_log[175], busy_log[176]); end
    $display("parity: even 0x07 observed");
    // odd parity, 0x07 -> parity bit 0
    sel = 2; li = -2;
    wd2 = 8'h07; wv2 = 1'b1;
    step();
    wv2 = 1'b0;
    repeat (177) step();
    add_frame(0, 9'h07, 8, 1, 1);
    exp_log[176] = 1'b1;
    d = first_diff(0, 177);
    total++; if (d != -1) begin bad++; $display("FAIL odd_frame: cycle %0d got %b want %b", d, tx_log[d], exp_log[d]); end
    total++; if (tx_log[152] !== 1'b0) begin bad++; $display("FAIL odd_parity_bit: got %b want 0", tx_log[152]); end
    $display("parity: odd 0x07 observed");
  endtask

  task automatic test_back_to_back();
    int d;
    logic [7:0] w [3];
    w[0] = 8'hA1; w[1] = 8'hB2; w[2] = 8'hC3;
    sel = 0; li = -2; peak = 0;
    wd0 = w[0]; wv0 = 1'b1;
    step();
    wd0 = w[1];
    step();
    wd0 = w[2];
    step();
    wv0 = 1'b0;
    repeat (479) step();
    for (int k = 0; k < 3; k++) add_frame(160 * k, {1'b0, w[k]}, 8, 0, 1);
    exp_log[480] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d = first_diff(160 * k, (k == 2) ? 481 : 160 * (k + 1));
      total++; if (d != -1) begin bad++; $display("FAIL b2b_frame%0d: cycle %0d got %b want %b", k, d, tx_log[d], exp_log[d]); end
    end
    total++; if (peak != 2) begin bad++; $display("FAIL b2b_peak_count: got %0d want 2", peak); end
    total++; if (busy_log[479] !== 1'b1 || busy_log[480] !== 1'b0)
      begin bad++; $display("FAIL b2b_length: busy %b%b want 10", busy_log[479], busy_log[480]); end
    $display("back_to_back: 3 frames observed");
  endtask

  task automatic test_full();
    int d;
    int idx;
    int iters;
    int full_seen;
    int full_bad;
    logic acc;
    logic [7:0] w [10];
    for (int i = 0; i < 10; i++) w[i] = 8'(8'h21 + i * 8'h13);
    sel = 0; li = -2; peak = 0;
    idx = 0; iters = 0; full_seen = 0; full_bad = 0;
    while (idx < 10 && iters < 400) begin
      wd0 = w[idx]; wv0 = 1'b1;
      acc = rdy0;
      step();
      iters++;
      if (acc) idx++;
      if (cnt0 == 4'd8) begin
        full_seen = 1;
        if (rdy0 !== 1'b0) full_bad++;
      end
    end
    wv0 = 1'b0;
    total++; if (idx != 10) begin bad++; $display("FAIL full_accept_timeout: got %0d words want 10", idx); end
    while (li < 1600) step();
    total++; if (full_seen != 1 || full_bad != 0)
      begin bad++; $display("FAIL full_ready_low: seen %0d bad_cycles %0d want 1 0", full_seen, full_bad); end
    total++; if (peak != 8) begin bad++; $display("FAIL full_peak: got %0d want 8", peak); end
    total++; if (cnt_log[159] != 8 || rdy_log[159] !== 1'b0)
      begin bad++; $display("FAIL full_before_pop: count %0d ready %b want 8 0", cnt_log[159], rdy_log[159]); end
    total++; if (cnt_log[160] != 7 || rdy_log[160] !== 1'b1)
      begin bad++; $display("FAIL full_pop_no_write: count %0d ready %b want 7 1", cnt_log[160], rdy_log[160]); end
    total++; if (cnt_log[161] != 8) begin bad++; $display("FAIL full_refill: got %0d want 8", cnt_log[161]); end
    for (int k = 0; k < 10; k++) add_frame(160 * k, {1'b0, w[k]}, 8, 0, 1);
    exp_log[1600] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      d = first_diff(160 * k, (k == 9) ? 1601 : 160 * (k + 1));
      total++; if (d != -1) begin bad++; $display("FAIL full_frame%0d: cycle %0d got %b want %b", k, d, tx_log[d], exp_log[d]); end
    end
    total++; if (busy_log[1600] !== 1'b0) begin bad++; $display("FAIL full_busy_end: got %b want 0", busy_log[1600]); end
    $display("full: 10 words offered and transmitted");
  endtask

  task automatic test_reset_midframe();
    int d;
    sel = 0; li = -2;
    wd0 = 8'h00; wv0 = 1'b1;
    step();
    wd0 = 8'hFF;
    step();
    wv0 = 1'b0;
    repeat (58) step();
    total++; if (tx0 !== 1'b0) begin bad++; $display("FAIL mid_in_data: got %b want 0", tx0); end
    #2 reset = 1'b0;
    #1;
    total++; if (tx0 !== 1'b1) begin bad++; $display("FAIL mid_tx_async: got %b want 1", tx0); end
    total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", cnt0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy0); end
    total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", rdy0); end
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    li = -2;
    wd0 = 8'h3C; wv0 = 1'b1;
    step();
    wv0 = 1'b0;
    repeat (161) step();
    add_frame(0, 9'h3C, 8, 0, 1);
    exp_log[160] = 1'b1;
    d = first_diff(0, 161);
    total++; if (d != -1) begin bad++; $display("FAIL mid_after_frame: cycle %0d got %b want %b", d, tx_log[d], exp_log[d]); end
    total++; if (busy_log[160] !== 1'b0) begin bad++; $display("FAIL mid_after_busy: got %b want 0", busy_log[160]); end
    $display("reset_midframe: abandon and recovery observed");
  endtask

  task automatic test_width_stop();
    int d;
    sel = 3; li = -2;
    wd3 = 7'h41; wv3 = 1'b1;
    step();
    wv3 = 1'b0;
    repeat (161) step();
    add_frame(0, 9'h41, 7, 0, 2);
    exp_log[160] = 1'b1;
    d = first_diff(0, 161);
    total++; if (d != -1) begin bad++; $display("FAIL w7s2_frame: cycle %0d got %b want %b", d, tx_log[d], exp_log[d]); end
    total++; if (tx_log[24] !== 1'b1 || tx_log[40] !== 1'b0 || tx_log[120] !== 1'b1)
      begin bad++; $display("FAIL w7s2_bits: got %b%b%b want 101", tx_log[24], tx_log[40], tx_log[120]); end
    total++; if (busy_log[159] !== 1'b1 || busy_log[160] !== 1'b0)
      begin bad++; $display("FAIL w7s2_length: busy %b%b want 10", busy_log[159], busy_log[160]); end
    $display("width_stop: 7-bit 2-stop 0x41 observed");
  endtask

  initial begin
    sel = 0; li = -2; peak = 0;
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_full();
    test_reset_midframe();
    test_width_stop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
